// File: rtl/foo_unaccum_if.sv
// Ready/valid stream carrying a 64-bit word plus a 129-bit wide word.
// Used both for the accumulator-side input and the recovered output.
interface foo_unaccum_if;
  logic         valid;
  logic         ready;
  logic [63:0]  data;
  logic [128:0] wide;

  modport master (output valid, output data, output wide, input ready);
  modport slave  (input valid, input data, input wide, output ready);
endinterface

// File: rtl/foo_unaccum.sv
// Inverse of the foo accumulator: recovers a = x[n] - x[n-1] - 1 and ~long,
// queued in a small first-word-fall-through FIFO behind a ready/valid output.
module foo_unaccum #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    resync_i,
  foo_unaccum_if.slave            in_if,
  foo_unaccum_if.master           out_if,
  output logic [$clog2(DEPTH):0]  outCount_o,
  output logic                    primed_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {PRIME, RUN} state_e;

  state_e        stateQ;
  logic [63:0]   prevXQ;
  logic [63:0]   aMemQ    [DEPTH];
  logic [128:0]  longMemQ [DEPTH];
  logic [AW-1:0] wrPtrQ, wrPtrD;
  logic [AW-1:0] rdPtrQ, rdPtrD;
  logic [CW-1:0] countQ, countD;

  logic          accept;
  logic          pop;
  logic          push;
  logic          priming;
  logic [63:0]   aNew;

  // in_ready depends only on state and occupancy, never on out_ready
  assign in_if.ready = (stateQ == PRIME) || (countQ != FULL_COUNT);
  assign accept      = in_if.valid && in_if.ready;
  assign pop         = out_if.valid && out_if.ready;
  assign priming     = (stateQ == PRIME) || resync_i;
  assign push        = accept && !priming;
  assign aNew        = in_if.data - prevXQ - 64'd1;

  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    if (push) wrPtrD = wrPtrQ + AW'(1);
    if (pop)  rdPtrD = rdPtrQ + AW'(1);
    case ({push, pop})
      2'b10:   countD = countQ + CW'(1);
      2'b01:   countD = countQ - CW'(1);
      default: countD = countQ;
    endcase
  end

  // A resync that coincides with an accept treats that sample as the primer
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= PRIME;
      prevXQ <= '0;
    end else if (accept && priming) begin
      stateQ <= RUN;
      prevXQ <= in_if.data;
    end else if (resync_i) begin
      stateQ <= PRIME;
    end else if (accept) begin
      prevXQ <= in_if.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        aMemQ[i]    <= '0;
        longMemQ[i] <= '0;
      end
    end else begin
      if (push) begin
        aMemQ[wrPtrQ]    <= aNew;
        longMemQ[wrPtrQ] <= ~in_if.wide;
      end
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
    end
  end

  assign out_if.valid = (countQ != '0);
  assign out_if.data  = aMemQ[rdPtrQ];
  assign out_if.wide  = longMemQ[rdPtrQ];
  assign outCount_o   = countQ;
  assign primed_o     = (stateQ == RUN);

endmodule

// File: tb/tb_foo_unaccum.sv
// Directed self-checking bench for foo_unaccum with hand-computed expectations.
module tb_foo_unaccum;

  logic       clk;
  logic       rst;
  logic       resync;
  logic [2:0] outCount;
  logic       primed;
  int         compareCount;
  int         failCount;
  logic [63:0] xAcc;

  foo_unaccum_if inIf();
  foo_unaccum_if outIf();

  foo_unaccum #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .resync_i   (resync),
    .in_if      (inIf),
    .out_if     (outIf),
    .outCount_o (outCount),
    .primed_o   (primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [192:0] observed,
                             input logic [192:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offer one word and hold it until accepted (bounded wait)
  task automatic applyStimulus(input logic [63:0] x, input logic [128:0] l);
    int budget;
    budget = 30;
    inIf.valid = 1'b1;
    inIf.data  = x;
    inIf.wide  = l;
    while (!inIf.ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!inIf.ready) begin
      checkOutput("acceptTimeout", 193'(0), 193'(1));
    end else begin
      tick();
    end
    inIf.valid = 1'b0;
  endtask

  task automatic popCheck(input string tag, input logic [63:0] expA,
                          input logic [128:0] expLong);
    checkOutput({tag, ".valid"}, 193'(outIf.valid), 193'(1));
    checkOutput({tag, ".a"}, 193'(outIf.data), 193'(expA));
    checkOutput({tag, ".long"}, 193'(outIf.wide), 193'(expLong));
    outIf.ready = 1'b1;
    tick();
    outIf.ready = 1'b0;
  endtask

  initial begin
    logic [128:0] allOnes;
    compareCount = 0;
    failCount    = 0;
    allOnes      = '1;
    rst          = 1'b1;
    resync       = 1'b0;
    inIf.valid   = 1'b0;
    inIf.data    = '0;
    inIf.wide    = '0;
    outIf.ready  = 1'b0;

    // 1: reset values, then basic recovery
    doReset();
    checkOutput("rst.outValid", 193'(outIf.valid), 193'(0));
    checkOutput("rst.count", 193'(outCount), 193'(0));
    checkOutput("rst.primed", 193'(primed), 193'(0));
    checkOutput("rst.outA", 193'(outIf.data), 193'(0));
    checkOutput("rst.outLong", 193'(outIf.wide), 193'(0));
    checkOutput("rst.inReady", 193'(inIf.ready), 193'(1));
    applyStimulus(64'd0, '0);
    checkOutput("t1.primed", 193'(primed), 193'(1));
    checkOutput("t1.noPushOnPrime", 193'(outIf.valid), 193'(0));
    applyStimulus(64'd6, '0);
    checkOutput("t1.latency", 193'(outIf.valid), 193'(1));
    applyStimulus(64'd13, '0);
    checkOutput("t1.count", 193'(outCount), 193'(2));
    popCheck("t1.w0", 64'd5, allOnes);
    popCheck("t1.w1", 64'd6, allOnes);
    checkOutput("t1.empty", 193'(outIf.valid), 193'(0));

    // 2: modular wrap in both directions
    doReset();
    applyStimulus(64'd5, '0);
    applyStimulus(64'd5, 129'h5);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 129'h0);
    applyStimulus(64'd4, allOnes);
    popCheck("t2.neg", 64'hFFFF_FFFF_FFFF_FFFF, ~129'h5);
    popCheck("t2.big", 64'hFFFF_FFFF_FFFF_FFF9, allOnes);
    popCheck("t2.wrap", 64'd4, 129'h0);

    // 3/4: back-pressure, full behaviour, pop-only-when-full, ordering
    doReset();
    xAcc = 64'd0;
    applyStimulus(xAcc, '0);
    for (int k = 1; k <= 4; k++) begin
      xAcc = xAcc + 64'(3 * k) + 64'd1;
      applyStimulus(xAcc, 129'(k));
    end
    checkOutput("t3.fullCount", 193'(outCount), 193'(4));
    checkOutput("t3.fullReady", 193'(inIf.ready), 193'(0));
    xAcc = xAcc + 64'd15 + 64'd1;
    inIf.valid = 1'b1;
    inIf.data  = xAcc;
    inIf.wide  = 129'd5;
    tick();
    tick();
    checkOutput("t3.heldCount", 193'(outCount), 193'(4));
    checkOutput("t3.head", 193'(outIf.data), 193'(3));
    outIf.ready = 1'b1;
    tick();
    outIf.ready = 1'b0;
    checkOutput("t4.popOnly", 193'(outCount), 193'(3));
    tick();
    inIf.valid = 1'b0;
    checkOutput("t4.refill", 193'(outCount), 193'(4));
    for (int k = 2; k <= 5; k++) begin
      popCheck($sformatf("t3.drain%0d", k), 64'(3 * k), ~129'(k));
    end
    for (int k = 6; k <= 10; k++) begin
      xAcc = xAcc + 64'(3 * k) + 64'd1;
      applyStimulus(xAcc, 129'(k));
      popCheck($sformatf("t3.word%0d", k), 64'(3 * k), ~129'(k));
    end
    checkOutput("t3.emptyEnd", 193'(outIf.valid), 193'(0));

    // 5: resync keeps queued words, next accept primes
    doReset();
    applyStimulus(64'd0, '0);
    applyStimulus(64'd10, '0);
    applyStimulus(64'd25, '0);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    checkOutput("t5.unprimed", 193'(primed), 193'(0));
    checkOutput("t5.kept", 193'(outCount), 193'(2));
    resync = 1'b1;
    applyStimulus(64'd100, '0);
    resync = 1'b0;
    checkOutput("t5.primedSame", 193'(primed), 193'(1));
    checkOutput("t5.noPush", 193'(outCount), 193'(2));
    applyStimulus(64'd110, '0);
    popCheck("t5.q0", 64'd9, allOnes);
    popCheck("t5.q1", 64'd14, allOnes);
    popCheck("t5.new", 64'd9, allOnes);
    checkOutput("t5.empty", 193'(outIf.valid), 193'(0));

    // 6: mid-stream reset discards queue and history
    doReset();
    applyStimulus(64'd0, '0);
    applyStimulus(64'd10, '0);
    applyStimulus(64'd25, '0);
    applyStimulus(64'd45, '0);
    checkOutput("t6.queued", 193'(outCount), 193'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6.outValid", 193'(outIf.valid), 193'(0));
    checkOutput("t6.count", 193'(outCount), 193'(0));
    checkOutput("t6.primed", 193'(primed), 193'(0));
    applyStimulus(64'd7, '0);
    checkOutput("t6.primeNoOut", 193'(outIf.valid), 193'(0));
    applyStimulus(64'd10, '0);
    popCheck("t6.first", 64'd2, allOnes);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
